shift_unit: RTL and testbench
=============================

Name: shift_unit

Overview:
- Multi-cycle shift/rotate engine for the datapath ALU.
- Generalises the single-op arithmetic right shift to five ops: SHR, SHRA, SHL, ROR and ROL.
- Parameterised operand width and bits shifted per cycle.
- The ALU control raises start during the execute step. The unit holds the result until the Z-load step, with a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; power of 2, at least 8.
- STEP, 1, bits shifted per iteration cycle; power of 2, 1 to WIDTH.

Ports:
- clock  input  1  single clock, rising edge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  shift op code (package encoding).
- operand  input  WIDTH  value to shift (Y register side).
- amount  input  WIDTH  shift count; only the low $clog2(WIDTH) bits are used (count mod WIDTH).
- busy  output  1  high while an operation is in flight (SHIFT or DONE state).
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  shifted value; holds until the next accepted start.
- zero  output  1  result == 0; registered with result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clear_n). On assertion the state goes to IDLE and busy, done, result and zero are all cleared to 0, including mid-operation. After release the unit waits for a fresh start.
- State machine has three states: IDLE, SHIFT and DONE.
- IDLE: when start=1 at an edge, the unit latches operand into acc, op into op_q, and n=amount[$clog2(WIDTH)-1:0] into cnt.
  - n!=0: go to SHIFT.
  - n==0: go to DONE.
- SHIFT: each edge shifts acc by s=min(STEP,cnt) and sets cnt-=s. When cnt reaches 0 the unit goes to DONE.
- DONE: result<=acc and zero<=(acc==0); done=1 for exactly this one cycle; next state is IDLE.
- Latency: done is high ceil(n/STEP)+1 cycles after the start edge. For n=0 this is 1 cycle.
- busy=1 in SHIFT and DONE; busy=0 in IDLE. start while busy is ignored, with no queueing.
- start in the same cycle done is high is ignored. start is accepted on the following IDLE cycle.
- Op semantics, per step of s bits:
  - SHR: zero fill.
  - SHRA: replicate acc[WIDTH-1].
  - SHL: zero fill from LSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Reserved op codes (5-7): pass operand through unchanged. The unit still sequences normally with cnt forced to 0, so done fires 1 cycle after start.
- Amount wrap: an amount of WIDTH or more uses only the low bits. For WIDTH=32, amount=33 behaves as 1 and amount=32 behaves as 0.
- result/zero change only in DONE. Between operations they hold their last values.

Optional Feature:
- Macro: SHIFT_UNIT_BARREL_EN.
- Defined: SHIFT state is never entered. IDLE with start goes straight to DONE, and DONE loads result from a combinational barrel shifter (log2(WIDTH) mux stages) on the latched acc/op_q/n. Latency is always 1 cycle; STEP is ignored. Handshake, reset and op semantics are identical.
- Undefined: iterative behaviour as above. No barrel logic is synthesised.

Decomposition:
- Package shift_pkg holds:
  - op typedef shift_op_t (3-bit) with SHR=0, SHRA=1, SHL=2, ROR=3, ROL=4.
  - state typedef with IDLE/SHIFT/DONE.
  - function shamt_w(WIDTH)=$clog2(WIDTH).
- One sub-module, shift_step: combinational single-step shifter (op, value, s) -> value. The FSM instantiates it once per cycle; the barrel build cascades it by 1,2,4,...

Test Plan:
- WIDTH=32, STEP=1, SHRA, operand=0xFFFFFFF0, amount=2 -> done pulses 3 cycles after start; result=0xFFFFFFFC; zero=0; busy high for 3 cycles.
- SHR operand=0x80000000 amount=31 with STEP=4 -> done after 9 cycles; result=0x00000001. Repeat with ROL operand=0x80000001 amount=1 -> result=0x00000003.
- SHL operand=0x0000000F amount=32 (wraps to 0) -> done after 1 cycle; result=0x0000000F. Then SHL amount=28 -> result=0xF0000000.
- Second start pulsed mid-operation and again during the done cycle -> both ignored; result matches the first op only. A start on the following IDLE cycle is accepted.
- clear_n driven low mid-SHIFT (ROR operand=0x12345678 amount=20) -> busy/done/result/zero go to 0 immediately. After release no done occurs until a new start.
- With SHIFT_UNIT_BARREL_EN, ROR operand=0x12345678 amount=8 -> done 1 cycle after start; result=0x78123456. SHRA 0x80000000 by 31 -> result=0xFFFFFFFF.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// Shared types and helpers for the multi-cycle shift/rotate engine.
// Op encodings, FSM state encoding and shift-amount width helper.
package shift_pkg;

  typedef enum logic [2:0] {
    SHR  = 3'd0,
    SHRA = 3'd1,
    SHL  = 3'd2,
    ROR  = 3'd3,
    ROL  = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned shamt_w(input int unsigned width);
    return $clog2(width);
  endfunction

  // Codes 5-7 are reserved and pass the operand through untouched.
  function automatic logic is_shift_op(input logic [2:0] op);
    return op <= 3'(ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts value by amt according to op.
// Reserved op codes return value unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = shamt_w(WIDTH)
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [SW:0]      amt,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned AW = SW + 1;

  logic [AW-1:0] inv_amt_c;

  // Complement distance for rotates; amt==0 yields WIDTH, which shifts to zero.
  assign inv_amt_c = AW'(WIDTH) - amt;

  always_comb begin
    result_c = value;
    case (op)
      SHR:     result_c = value >> amt;
      SHRA:    result_c = WIDTH'($signed(value) >>> amt);
      SHL:     result_c = value << amt;
      ROR:     result_c = (value >> amt) | (value << inv_amt_c);
      ROL:     result_c = (value << amt) | (value >> inv_amt_c);
      default: result_c = value;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate engine with start/done handshake.
// Define SHIFT_UNIT_BARREL_EN for a single-cycle barrel shifter instead of iteration.
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned SW = shamt_w(WIDTH);
  localparam int unsigned AW = SW + 1;
  localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [2:0]       op_q, op_d;
  logic [SW-1:0]    cnt, cnt_d;

  logic [WIDTH-1:0] load_val_c;
  logic [SW-1:0]    load_cnt_c;
  logic [WIDTH-1:0] step_val_c;
  logic [AW-1:0]    step_amt_c;
  logic             unused_c;

  // Only the count modulo WIDTH matters.
  assign unused_c = &{1'b0, amount[WIDTH-1:SW]};

`ifdef SHIFT_UNIT_BARREL_EN
  logic [WIDTH-1:0] stage_c [SW+1];

  // log2(WIDTH) cascaded stages shifting by 1,2,4,... selected by amount bits.
  assign stage_c[0] = operand;
  for (genvar k = 0; k < SW; k++) begin : g_barrel
    logic [AW-1:0] k_amt_c;
    assign k_amt_c = amount[k] ? AW'(2 ** k) : '0;
    shift_step #(.WIDTH(WIDTH), .SW(SW)) u_stage (
      .op       (op),
      .value    (stage_c[k]),
      .amt      (k_amt_c),
      .result_c (stage_c[k+1])
    );
  end

  assign load_val_c = stage_c[SW];
  assign load_cnt_c = '0;
`else
  assign load_val_c = operand;
  assign load_cnt_c = is_shift_op(op) ? amount[SW-1:0] : '0;
`endif

  // Per-iteration distance is min(STEP, cnt).
  assign step_amt_c = ({1'b0, cnt} < STEP_AMT) ? {1'b0, cnt} : STEP_AMT;

  shift_step #(.WIDTH(WIDTH), .SW(SW)) u_step (
    .op       (op_q),
    .value    (acc),
    .amt      (step_amt_c),
    .result_c (step_val_c)
  );

  always_comb begin
    state_d = state;
    acc_d   = acc;
    op_d    = op_q;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          acc_d   = load_val_c;
          op_d    = op;
          cnt_d   = load_cnt_c;
          state_d = (load_cnt_c == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d = step_val_c;
        cnt_d = cnt - step_amt_c[SW-1:0];
        if (cnt_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      acc   <= '0;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      op_q  <= op_d;
      cnt   <= cnt_d;
    end
  end

  // Result is captured on the edge entering DONE so it is valid alongside done.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      if (state_d == DONE) begin
        result <= acc_d;
        zero   <= (acc_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: STEP=1 and STEP=4 instances share stimulus.
// Handles both the iterative build and SHIFT_UNIT_BARREL_EN.
module tb_shift_unit;
  import shift_pkg::*;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         clear_n, start;
  logic [2:0]   op;
  logic [W-1:0] operand, amount;
  logic         busy1, done1, zero1, busy4, done4, zero4;
  logic [W-1:0] result1, result4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clock(clock), .clear_n(clear_n), .start(start), .op(op), .operand(operand),
    .amount(amount), .busy(busy1), .done(done1), .result(result1), .zero(zero1)
  );

  shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clock(clock), .clear_n(clear_n), .start(start), .op(op), .operand(operand),
    .amount(amount), .busy(busy4), .done(done4), .result(result4), .zero(zero4)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] operand;
    logic [31:0] amount;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[17];

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input int step);
    int n;
    n = (o <= 3'd4) ? int'(a[4:0]) : 0;
`ifdef SHIFT_UNIT_BARREL_EN
    return 1 + (n * 0);
`else
    return (n + step - 1) / step + 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat1, lat4, e1, e4;
    logic [31:0] r1, r4;
    logic z1, z4, b1, b4;
    lat1 = -1; lat4 = -1;
    r1 = 'x; r4 = 'x; z1 = 1'bx; z4 = 1'bx; b1 = 1'bx; b4 = 1'bx;
    e1 = exp_lat(v.op, v.amount, 1);
    e4 = exp_lat(v.op, v.amount, 4);
    @(negedge clock);
    op = v.op; operand = v.operand; amount = v.amount; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clock);
      if (done1) begin
        if (lat1 < 0) begin lat1 = c; r1 = result1; z1 = zero1; b1 = busy1; end
        else chk($sformatf("v%0d_done1_pulse", idx), 32'(c), 32'(lat1));
      end
      if (done4) begin
        if (lat4 < 0) begin lat4 = c; r4 = result4; z4 = zero4; b4 = busy4; end
        else chk($sformatf("v%0d_done4_pulse", idx), 32'(c), 32'(lat4));
      end
      if (lat1 >= 0 && lat4 >= 0 && c > lat1 && c > lat4) begin
        chk($sformatf("v%0d_idle_busy1", idx), 32'(busy1), 32'd0);
        chk($sformatf("v%0d_idle_busy4", idx), 32'(busy4), 32'd0);
        chk($sformatf("v%0d_hold_res1", idx), result1, v.exp_res);
        break;
      end
    end
    chk($sformatf("v%0d_lat1", idx), 32'(lat1), 32'(e1));
    chk($sformatf("v%0d_lat4", idx), 32'(lat4), 32'(e4));
    chk($sformatf("v%0d_res1", idx), r1, v.exp_res);
    chk($sformatf("v%0d_res4", idx), r4, v.exp_res);
    chk($sformatf("v%0d_zero1", idx), 32'(z1), 32'(v.exp_zero));
    chk($sformatf("v%0d_zero4", idx), 32'(z4), 32'(v.exp_zero));
    chk($sformatf("v%0d_busy_at_done1", idx), 32'(b1), 32'd1);
    chk($sformatf("v%0d_busy_at_done4", idx), 32'(b4), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d4, t1, t4;

    vecs[0]  = '{SHRA, 32'hFFFF_FFF0, 32'd2,  32'hFFFF_FFFC, 1'b0};
    vecs[1]  = '{SHR,  32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0};
    vecs[2]  = '{ROL,  32'h8000_0001, 32'd1,  32'h0000_0003, 1'b0};
    vecs[3]  = '{SHL,  32'h0000_000F, 32'd32, 32'h0000_000F, 1'b0};
    vecs[4]  = '{SHL,  32'h0000_000F, 32'd28, 32'hF000_0000, 1'b0};
    vecs[5]  = '{ROR,  32'h1234_5678, 32'd8,  32'h7812_3456, 1'b0};
    vecs[6]  = '{SHRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{SHR,  32'h0000_0001, 32'd1,  32'h0000_0000, 1'b1};
    vecs[8]  = '{ROR,  32'h1234_5678, 32'd33, 32'h091A_2B3C, 1'b0};
    vecs[9]  = '{3'd5, 32'hDEAD_BEEF, 32'd7,  32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{ROL,  32'h1234_5678, 32'd4,  32'h2345_6781, 1'b0};
    vecs[11] = '{SHL,  32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 1'b0};
    vecs[12] = '{SHRA, 32'h7FFF_FFFF, 32'd30, 32'h0000_0001, 1'b0};
    vecs[13] = '{ROR,  32'h0000_0001, 32'd31, 32'h0000_0002, 1'b0};
    vecs[14] = '{SHR,  32'h0000_0000, 32'd5,  32'h0000_0000, 1'b1};
    vecs[15] = '{SHRA, 32'h8000_0000, 32'd64, 32'h8000_0000, 1'b0};
    vecs[16] = '{ROR,  32'h1234_5678, 32'd20, 32'h4567_8123, 1'b0};

    clear_n = 1'b0; start = 1'b0; op = '0; operand = '0; amount = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_res1", result1, 32'd0);
    chk("rst_zero1", 32'(zero1), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_res4", result4, 32'd0);
    chk("rst_zero4", 32'(zero4), 32'd0);
    clear_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

`ifndef SHIFT_UNIT_BARREL_EN
    // Starts mid-operation and during dut4's done cycle must be ignored.
    d1 = 0; d4 = 0; t1 = -1; t4 = -1;
    @(negedge clock);
    op = SHR; operand = 32'h8000_0000; amount = 32'd31; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clock);
      if (done1) begin d1++; t1 = c; chk("midop_res1", result1, 32'h0000_0001); end
      if (done4) begin d4++; t4 = c; chk("midop_res4", result4, 32'h0000_0001); end
      if (c == 3 || c == 9) begin op = SHL; operand = 32'h0000_0001; amount = 32'd1; start = 1'b1; end
      if (c == 4 || c == 10) start = 1'b0;
    end
    chk("midop_cnt1", 32'(d1), 32'd1);
    chk("midop_cnt4", 32'(d4), 32'd1);
    chk("midop_t1", 32'(t1), 32'd32);
    chk("midop_t4", 32'(t4), 32'd9);
    chk("midop_busy4", 32'(busy4), 32'd0);
`endif

    // Start held through the done cycle is accepted on the next IDLE cycle.
    @(negedge clock);
    op = SHL; operand = 32'h0000_000F; amount = 32'd0; start = 1'b1;
    @(negedge clock);
    chk("b2b_done1", 32'(done1), 32'd1);
    chk("b2b_done4", 32'(done4), 32'd1);
    chk("b2b_res1", result1, 32'h0000_000F);
    chk("b2b_res4", result4, 32'h0000_000F);
    op = SHR; operand = 32'h0000_0F00; amount = 32'd4;
    @(negedge clock);
    chk("b2b_gap_done1", 32'(done1), 32'd0);
    chk("b2b_gap_busy4", 32'(busy4), 32'd0);
    chk("b2b_gap_res1", result1, 32'h0000_000F);
    t1 = -1; t4 = -1;
    for (int c = 3; c <= 20; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done1 && t1 < 0) begin t1 = c; chk("b2b_res2_1", result1, 32'h0000_00F0); end
      if (done4 && t4 < 0) begin t4 = c; chk("b2b_res2_4", result4, 32'h0000_00F0); end
    end
    chk("b2b_t1", 32'(t1), 32'(2 + exp_lat(SHR, 32'd4, 1)));
    chk("b2b_t4", 32'(t4), 32'(2 + exp_lat(SHR, 32'd4, 4)));

    // Asynchronous clear in the middle of a long rotate.
    @(negedge clock);
    op = ROR; operand = 32'h1234_5678; amount = 32'd20; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    chk("clr_busy1", 32'(busy1), 32'd0);
    chk("clr_done1", 32'(done1), 32'd0);
    chk("clr_res1", result1, 32'd0);
    chk("clr_zero1", 32'(zero1), 32'd0);
    chk("clr_busy4", 32'(busy4), 32'd0);
    chk("clr_res4", result4, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    d1 = 0; d4 = 0;
    repeat (30) begin
      @(negedge clock);
      if (done1) d1++;
      if (done4) d4++;
    end
    chk("clr_no_done1", 32'(d1), 32'd0);
    chk("clr_no_done4", 32'(d4), 32'd0);
    chk("clr_idle_busy1", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
